// File: rtl/serial_word_tx.sv
// MSB-first parallel-to-serial word transmitter with a programmable bit period.
// All outputs are flops loaded from the next-state decode, so start/din never reach an output combinationally.
//
//   state | meaning
//   IDLE  | waiting for start; sdata/busy low
//   SHIFT | driving shift_q[N-1]; divider paces each bit
//   DONE  | one-cycle tail holding the LSB; a start here chains the next frame
module serial_word_tx #(
  parameter int N       = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] din,
  output logic         sdata,
  output logic         bit_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(N);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic            sdata_q, sdata_d;
  logic            bit_valid_q, bit_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d   = din;
          bit_cnt_d = BIT_LAST;
          div_d     = '0;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          // The final bit is not shifted out, so DONE still presents the LSB.
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
            div_d     = '0;
          end else begin
            state_d   = DONE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    bit_valid_d = (state_d == SHIFT) && (div_d == '0);
    sdata_d     = (state_d != IDLE) && shift_d[N-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      sdata_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      sdata_q     <= sdata_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sdata     = sdata_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter for N-bit fixed-point datapath words.
- Captures a word on a start request and shifts it out MSB first, one bit per programmable bit period.
- Raises a one-cycle done pulse when the last bit has been sent.
- Forms the transmit end of the serial link; the receive end reassembles bits into the datapath's N-bit async-reset register stage.

Parameters:
- N, 16, word width in bits (must be ≥ 2).
- CLK_DIV, 4, clk cycles per serial bit (must be ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transmit request; sampled on the rising edge of clk.
- din  input  N  word to send; captured on an accepted start.
- sdata  output  1  serial data, registered.
- bit_valid  output  1  one-cycle strobe in the first clk of every bit period.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse in the last clk of the last bit.

Behaviour:
- **Reset values:** on reset, outputs go immediately to sdata=0, bit_valid=0, busy=0, done=0. Internal state resets to state=IDLE, shift register=0, bit counter=0, divider counter=0.
- **Reset mid-frame:** the frame is abandoned; nothing resumes after reset is released.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - busy=0, sdata=0.
  - start=1 at an edge is accepted: din is loaded into the shift register, the bit counter is set to N-1, the divider counter to 0, and the state moves to SHIFT.
- **SHIFT:**
  - sdata = shift_reg[N-1].
  - bit_valid=1 when divider counter==0.
  - The divider counts 0..CLK_DIV-1.
  - When divider==CLK_DIV-1 and bit counter>0: shift left by one (zero fill), decrement the bit counter, clear the divider.
  - When divider==CLK_DIV-1 and bit counter==0: go to DONE.
- **DONE:**
  - Lasts exactly one cycle; done=1 and busy=1.
  - sdata holds the LSB value.
  - Returns to IDLE next cycle, unless start=1 in this cycle. In that case the new din is loaded and the block goes straight to SHIFT (back-to-back frames with no idle gap).
- **Latency:**
  - Start accepted at edge k: the first bit appears on sdata after edge k.
  - The frame occupies N·CLK_DIV cycles in SHIFT plus 1 cycle in DONE.
  - Each bit is held for exactly CLK_DIV cycles, except the last bit, which is held CLK_DIV+1 cycles (extended by the DONE cycle).
- **Rules while busy:**
  - start during SHIFT is ignored and not queued.
  - din is don't-care except on an accepted start.
- **CLK_DIV=1:** bit_valid is high every SHIFT cycle, one bit per clk.
- **Counter widths:**
  - Bit counter: clog2(N) bits.
  - Divider: clog2(CLK_DIV) bits, minimum 1.
  - No wrap-around is permitted beyond the stated terminal values.
- **Registering:** all outputs are registered or decoded from registered state only. There is no combinational path from start or din to any output.

Test Plan:
1. Reset then idle, N=16, CLK_DIV=4, start=0 for 20 cycles → sdata=0, busy=0, done=0, bit_valid=0 throughout.
2. Single frame, din=16'hA5C3, start pulsed one cycle:
   - sdata sequence over 64 cycles is 1010_0101_1100_0011, each bit held 4 clk.
   - 16 bit_valid strobes, spaced 4 clk apart.
   - done high exactly once, at cycle 65 after acceptance.
   - busy then falls to 0.
3. Start ignored while busy: start=1 held for 10 cycles during a 16'h8001 frame.
   - Frame output is unchanged: 1, then 14 zeros, then 1.
   - After done, a held start launches the next frame in the cycle after the DONE cycle.
4. Back-to-back: din=16'hFFFF sent, then start=1 with din=16'h0000 during the DONE cycle.
   - The second frame's first bit (0) follows the DONE cycle with no IDLE cycle.
   - busy stays 1 continuously across both frames.
5. Reset mid-frame: assert reset at bit 7 of a 16'h1234 frame.
   - Outputs go to 0 immediately, without waiting for an edge.
   - After release, the block stays in IDLE until a new start.
   - A new start with 16'h00FF transmits correctly from the MSB.
6. CLK_DIV=1, N=8 build, din=8'h96 → sdata=1,0,0,1,0,1,1,0 on consecutive cycles; bit_valid=1 every cycle; done on the 9th cycle.
